// File: rtl/tr_buffer_loader.sv
// tr_buffer_loader: assembles a serial 14-bit syllable (4-bit opcode, 9-bit address, odd parity) and hands the address to the transfer register
//   CLK, RSTN        clock, async active-low reset
//   RDV, MSEL        read request (taken only in IDLE) and module select latched with it (0 = A, 1 = B)
//   SDA, SDB, BSTB   serial sense data of modules A/B, one bit taken per BSTB cycle, bit 1 first
//   TRACK            transfer register has taken the field; releases HOLD
//   BRA, BRB         buffer registers, bit 0 = address bit A1
//   MAOV, MBOV, TBR  module field valid flags and one-cycle load strobe
//   OP, PERR, BUSY   opcode of last good syllable, sticky parity error, not-idle flag
module tr_buffer_loader #(
  parameter int SYL_BITS  = 14,
  parameter int ADDR_BITS = 9
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 RDV,
  input  logic                 MSEL,
  input  logic                 SDA,
  input  logic                 SDB,
  input  logic                 BSTB,
  input  logic                 TRACK,
  output logic [ADDR_BITS-1:0] BRA,
  output logic [ADDR_BITS-1:0] BRB,
  output logic                 MAOV,
  output logic                 MBOV,
  output logic                 TBR,
  output logic [3:0]           OP,
  output logic                 PERR,
  output logic                 BUSY
);
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, XFER, HOLD} state_t;
  state_t state, state_d;
  logic [SYL_BITS-1:0] sr;
  logic [3:0] cnt;
  logic msel;
  logic last_bit;
  logic good;
  assign last_bit = BSTB && cnt == 4'(SYL_BITS - 1);
  assign good     = ^sr;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = RDV ? SHIFT : IDLE;
      SHIFT:   state_d = last_bit ? CHECK : SHIFT;
      CHECK:   state_d = good ? XFER : IDLE;
      XFER:    state_d = HOLD;
      HOLD:    state_d = TRACK ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else       state <= state_d;
  // sr[k] holds syllable bit k+1: [3:0] opcode, [12:4] address, [13] parity
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sr   <= '0;
      cnt  <= '0;
      msel <= 1'b0;
      BRA  <= '0;
      BRB  <= '0;
      OP   <= '0;
      PERR <= 1'b0;
    end else begin
      if (state == IDLE && RDV) begin
        msel <= MSEL;
        sr   <= '0;
        cnt  <= '0;
        PERR <= 1'b0;
      end
      if (state == SHIFT && BSTB) begin
        sr[cnt] <= msel ? SDB : SDA;
        cnt     <= cnt + 4'd1;
      end
      if (state == CHECK) begin
        if (good) begin
          OP <= sr[3:0];
          if (msel) BRB <= sr[4 +: ADDR_BITS];
          else      BRA <= sr[4 +: ADDR_BITS];
        end else begin
          PERR <= 1'b1;
        end
      end
    end
  end
  // valid flags are decoded from state so they drop on the same edge TRACK leaves HOLD
  assign TBR  = state == XFER;
  assign MAOV = (state == XFER || state == HOLD) && !msel;
  assign MBOV = (state == XFER || state == HOLD) && msel;
  assign BUSY = state != IDLE;
endmodule

// File: tb/tb_tr_buffer_loader.sv
// tb_tr_buffer_loader: directed reads with a scoreboard checking each TBR transfer of tr_buffer_loader
module tb_tr_buffer_loader;
  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       RDV = 1'b0, MSEL = 1'b0, SDA = 1'b0, SDB = 1'b0, BSTB = 1'b0, TRACK = 1'b0;
  logic [8:0] BRA, BRB;
  logic       MAOV, MBOV, TBR, PERR, BUSY;
  logic [3:0] OP;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [8:0] bra;
    logic [8:0] brb;
    logic [3:0] op;
    logic       maov;
    logic       mbov;
  } exp_t;
  exp_t q[$];
  // syllables as {parity, address A9..A1, opcode}; v[k] is serial bit k+1
  localparam logic [13:0] V1  = {1'b1, 9'h0A5, 4'h5};
  localparam logic [13:0] V2  = {1'b0, 9'h15A, 4'hA};
  localparam logic [13:0] BAD = {1'b0, 9'h0A5, 4'h5};

  tr_buffer_loader dut (
    .CLK(CLK), .RSTN(RSTN), .RDV(RDV), .MSEL(MSEL), .SDA(SDA), .SDB(SDB),
    .BSTB(BSTB), .TRACK(TRACK), .BRA(BRA), .BRB(BRB), .MAOV(MAOV), .MBOV(MBOV),
    .TBR(TBR), .OP(OP), .PERR(PERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // scoreboard monitor: every TBR strobe must match the oldest pending expectation
  always @(negedge CLK) begin
    if (RSTN && TBR) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tbr: got TBR=1 expected no transfer at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_bra", BRA, e.bra);
        chk("sb_brb", BRB, e.brb);
        chk("sb_op", OP, e.op);
        chk("sb_maov", MAOV, e.maov);
        chk("sb_mbov", MBOV, e.mbov);
      end
    end
  end

  task automatic do_read(input logic m, input logic [13:0] v, input int gap,
                         input logic good, input logic noise);
    RDV = 1'b1; MSEL = m; BSTB = 1'b1; SDA = ~v[0]; SDB = ~v[0];
    tick;
    chk("rdv_clears_perr", PERR, 0);
    chk("busy_after_rdv", BUSY, 1);
    RDV = 1'b0; BSTB = 1'b0; MSEL = ~m;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) repeat (gap) tick;
      if (noise && i == 5) begin
        RDV = 1'b1; TRACK = 1'b1;
        tick;
        RDV = 1'b0; TRACK = 1'b0;
      end
      SDA = m ? ~v[i] : v[i];
      SDB = m ? v[i] : ~v[i];
      BSTB = 1'b1;
      tick;
      BSTB = 1'b0;
    end
    chk("tbr_in_check", TBR, 0);
    tick;
    if (good) begin
      chk("tbr_latency", TBR, 1);
      chk("xfer_maov", MAOV, !m);
      chk("xfer_mbov", MBOV, m);
      if (noise) TRACK = 1'b1;
      tick;
      TRACK = 1'b0;
      chk("tbr_one_cycle", TBR, 0);
      chk("hold_busy", BUSY, 1);
      repeat (2) begin
        RDV = 1'b1;
        tick;
        RDV = 1'b0;
      end
      chk("hold_maov", MAOV, !m);
      chk("hold_mbov", MBOV, m);
      TRACK = 1'b1;
      tick;
      TRACK = 1'b0;
      chk("release_maov", MAOV, 0);
      chk("release_mbov", MBOV, 0);
      chk("release_busy", BUSY, 0);
    end else begin
      chk("bad_no_tbr", TBR, 0);
      chk("bad_idle", BUSY, 0);
      chk("bad_perr", PERR, 1);
    end
  endtask

  initial begin
    #2;
    chk("rst_bra", BRA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_tbr", TBR, 0);
    repeat (2) tick;
    RSTN = 1'b1;
    tick;
    q.push_back('{bra: 9'h0A5, brb: 9'h000, op: 4'h5, maov: 1'b1, mbov: 1'b0});
    do_read(1'b0, V1, 0, 1'b1, 1'b0);
    q.push_back('{bra: 9'h0A5, brb: 9'h0A5, op: 4'h5, maov: 1'b0, mbov: 1'b1});
    do_read(1'b1, V1, 2, 1'b1, 1'b1);
    q.push_back('{bra: 9'h15A, brb: 9'h0A5, op: 4'hA, maov: 1'b1, mbov: 1'b0});
    do_read(1'b0, V2, 1, 1'b1, 1'b1);
    do_read(1'b1, BAD, 0, 1'b0, 1'b0);
    chk("bad_bra_kept", BRA, 9'h15A);
    chk("bad_brb_kept", BRB, 9'h0A5);
    chk("bad_op_kept", OP, 4'hA);
    q.push_back('{bra: 9'h15A, brb: 9'h15A, op: 4'hA, maov: 1'b0, mbov: 1'b1});
    do_read(1'b1, V2, 0, 1'b1, 1'b0);
    RDV = 1'b1; MSEL = 1'b0;
    tick;
    RDV = 1'b0;
    for (int i = 0; i < 7; i++) begin
      SDA = V1[i]; BSTB = 1'b1;
      tick;
      BSTB = 1'b0;
    end
    RSTN = 1'b0;
    #1;
    chk("abort_bra", BRA, 0);
    chk("abort_brb", BRB, 0);
    chk("abort_op", OP, 0);
    chk("abort_flags", {MAOV, MBOV, TBR, PERR, BUSY}, 0);
    tick;
    RSTN = 1'b1;
    tick;
    q.push_back('{bra: 9'h0A5, brb: 9'h000, op: 4'h5, maov: 1'b1, mbov: 1'b0});
    do_read(1'b0, V1, 0, 1'b1, 1'b0);
    repeat (3) tick;
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tr_buffer_loader.md
Name: tr_buffer_loader

Overview:
- Upstream feeder for the 9-bit transfer register. Assembles one 14-bit instruction syllable serially from memory module A or B: 4-bit opcode, 9-bit operand address, 1 parity bit.
- Checks odd parity, then presents the address field on buffer-register lines BRA/BRB with module-valid flags MAOV/MBOV and a one-cycle TBR load strobe.
- The transfer register consumes these signals. The opcode field goes to the op decoder.

Parameters:
SYL_BITS, 14, total serial bits per syllable including parity (fixed; the address-field layout below depends on it)
ADDR_BITS, 9, width of address field delivered to transfer register

Ports:
- CLK  input  1  single system clock; all state changes on rising edge
- RSTN  input  1  reset: asynchronous, active-low
- RDV  input  1  read request; sampled only in IDLE
- MSEL  input  1  module select for the read: 0 = module A, 1 = module B; latched with RDV
- SDA  input  1  serial sense data, module A
- SDB  input  1  serial sense data, module B
- BSTB  input  1  bit-time strobe; one serial bit accepted per cycle with BSTB=1
- TRACK  input  1  transfer register has taken the field; releases HOLD
- BRA  output  9  buffer register A, address bits A1..A9 (BRA[0]=A1)
- BRB  output  9  buffer register B, same layout
- MAOV  output  1  module A field valid
- MBOV  output  1  module B field valid
- TBR  output  1  transfer-buffer-to-register strobe, one cycle
- OP  output  4  opcode field of last good syllable
- PERR  output  1  sticky parity error
- BUSY  output  1  high in every state except IDLE

Behaviour:
- Reset (async, RSTN=0): state IDLE; shift register, bit count and module latch cleared. Outputs BRA=0, BRB=0, OP=0, MAOV=MBOV=TBR=PERR=BUSY=0.
- States: IDLE, SHIFT, CHECK, XFER, HOLD.
- IDLE:
  - RDV=1 latches MSEL, clears the shift register, clears bit count to 0 and clears PERR.
  - Next state SHIFT.
  - A BSTB in the same cycle as RDV is ignored.
- SHIFT:
  - On each BSTB=1, the selected module's data bit (SDA or SDB per latched MSEL) is stored as syllable bit k+1 (k = bit count), and the count increments.
  - Bit 1 is received first.
  - Cycles without BSTB hold all state.
  - When the 14th bit is stored, next state is CHECK.
- CHECK (1 cycle): compute the XOR of all 14 bits.
  - Result 1 (odd parity, good):
    - bits 1-4 load OP, bit 1 = OP[0];
    - bits 5-13 load BRA if module A, else BRB (bit 5 = A1); the other register holds its value;
    - next state XFER.
  - Result 0 (bad): PERR=1; BRA, BRB and OP unchanged; next state IDLE.
- XFER:
  - TBR=1 for exactly this cycle.
  - MAOV=1 if module A, MBOV=1 if module B; never both.
  - Next state HOLD.
- HOLD:
  - MAOV/MBOV stay asserted; BRA/BRB stable.
  - TRACK=1 -> IDLE, and MAOV/MBOV deassert on the same edge.
  - No timeout.
- Latency: TBR asserts 2 cycles after the edge that accepts the 14th bit (CHECK, then XFER).
- RDV is ignored whenever BUSY=1. TRACK is ignored outside HOLD. TRACK asserted during XFER is not remembered.
- PERR stays set until the next accepted RDV or reset.
- Reset mid-read or mid-HOLD aborts immediately. No TBR is issued and the partial syllable is discarded.
- BRA/BRB retain their last good value across reads of the other module.

Test Plan:
- Reset mid-SHIFT after 7 strobes -> all outputs 0, state IDLE; the next RDV read completes normally.
- Module A good read: RDV with MSEL=0, serial bits 1..14 = 1,0,1,0, 1,0,1,0,0,1,0,1,0, 1 (OP=5, addr=0x0A5, parity ok) -> 2 cycles after the last strobe TBR=1 for one cycle, MAOV=1, BRA=0x0A5, OP=4'h5, BRB unchanged (0). MAOV drops on the edge after TRACK=1.
- Module B read with gaps: same data via SDB, MSEL=1, BSTB high every 3rd cycle, SDA driven with inverted data -> BRB=0x0A5, MBOV=1, BRA keeps its previous value, MAOV=0 throughout.
- Parity fault: same data but bit 14 = 0 -> PERR=1, no TBR, BRA/BRB/OP unchanged, BUSY=0 one cycle after CHECK. A following good RDV clears PERR.
- Busy rules: RDV pulses during SHIFT and HOLD ignored (count and MSEL latch unchanged); TRACK during SHIFT/XFER does not shorten HOLD; the BSTB coincident with the accepted RDV is not counted (bit 1 = first later strobe).
